// File: rtl/nano_pkg.sv
// Purpose: shared types and constants for the NanoProcessor control path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: sequencer state enum, opcodes, bus-select codes, instruction field positions.
package nano_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_T1    = 3'd2,
        ST_T2    = 3'd3,
        ST_T3    = 3'd4
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JNZ = 3'b101;

    localparam logic [3:0] SEL_G   = 4'd8;
    localparam logic [3:0] SEL_DIN = 4'd9;

    // Instruction word layout: {op[2:0], rx[2:0], ry[2:0]} in the low 9 bits.
    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 5;
    localparam int RX_LSB = 3;
    localparam int RY_MSB = 2;
    localparam int RY_LSB = 0;

    function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/load_register.sv
// Purpose: W-bit register with synchronous reset and load enable (IR here, A/G in the datapath).
// Latency: 1 cycle from load to q.
// Backpressure: none; q holds its value whenever load is low.
// Ports: clock, sreset (sync, active-high), load, d[W-1:0] -> q[W-1:0].
module load_register #(
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         sreset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (sreset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Purpose: fetch/decode/execute control FSM; sole master of the program counter.
// Latency: FETCH to done is 2 cycles (mv/mvi/jmp/jnz/nop) or 4 cycles (add/sub).
// Backpressure: none; run gates entry from IDLE and continuation after each done.
// Ports: clock, sreset, run, instr, bus_value, g_zero in; PC controls (pc_count_enable,
//        pc_sload, pc_data), datapath controls (reg_write, bus_sel, a_load, g_load, alu_sub), done out.
module instruction_sequencer
    import nano_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         sreset,
    input  logic         run,
    input  logic [W-1:0] instr,
    input  logic [W-1:0] bus_value,
    input  logic         g_zero,
    output logic         pc_count_enable,
    output logic         pc_sload,
    output logic [N-1:0] pc_data,
    output logic [7:0]   reg_write,
    output logic [3:0]   bus_sel,
    output logic         a_load,
    output logic         g_load,
    output logic         alu_sub,
    output logic         done
);

    state_t       state;
    state_t       state_nxt;
    logic         ir_load;
    logic [W-1:0] ir;
    logic [2:0]   op;
    logic [2:0]   rx;
    logic [2:0]   ry;

    // Upper instruction bits and upper bus bits are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{ir, bus_value};

    load_register #(.W(W)) u_ir (
        .clock  (clock),
        .sreset (sreset),
        .load   (ir_load),
        .d      (instr),
        .q      (ir)
    );

    assign op = ir[OP_MSB:OP_LSB];
    assign rx = ir[RX_MSB:RX_LSB];
    assign ry = ir[RY_MSB:RY_LSB];

    always_ff @(posedge clock) begin
        if (sreset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        ir_load         = 1'b0;
        pc_count_enable = 1'b0;
        pc_sload        = 1'b0;
        pc_data         = '0;
        reg_write       = '0;
        bus_sel         = '0;
        a_load          = 1'b0;
        g_load          = 1'b0;
        alu_sub         = 1'b0;
        done            = 1'b0;

        case (state)
            ST_IDLE: begin
                state_nxt = run ? ST_FETCH : ST_IDLE;
            end

            ST_FETCH: begin
                // instr is the word at the current PC; advancing the PC here makes
                // the following word (mvi immediate or next opcode) visible in T1.
                ir_load         = 1'b1;
                pc_count_enable = 1'b1;
                state_nxt       = ST_T1;
            end

            ST_T1: begin
                case (op)
                    OP_MV: begin
                        bus_sel   = {1'b0, ry};
                        reg_write = reg_onehot(rx);
                        done      = 1'b1;
                    end
                    OP_MVI: begin
                        // The immediate sits at the current PC; step past it.
                        bus_sel         = SEL_DIN;
                        reg_write       = reg_onehot(rx);
                        pc_count_enable = 1'b1;
                        done            = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel = {1'b0, rx};
                        a_load  = 1'b1;
                    end
                    OP_JMP: begin
                        bus_sel  = {1'b0, ry};
                        pc_sload = 1'b1;
                        pc_data  = bus_value[N-1:0];
                        done     = 1'b1;
                    end
                    OP_JNZ: begin
                        bus_sel = {1'b0, ry};
                        if (!g_zero) begin
                            pc_sload = 1'b1;
                            pc_data  = bus_value[N-1:0];
                        end
                        done = 1'b1;
                    end
                    default: begin
                        done = 1'b1;
                    end
                endcase

                if (op == OP_ADD || op == OP_SUB) begin
                    state_nxt = ST_T2;
                end else begin
                    state_nxt = run ? ST_FETCH : ST_IDLE;
                end
            end

            ST_T2: begin
                bus_sel   = {1'b0, ry};
                g_load    = 1'b1;
                alu_sub   = (op == OP_SUB);
                state_nxt = ST_T3;
            end

            ST_T3: begin
                bus_sel   = SEL_G;
                reg_write = reg_onehot(rx);
                done      = 1'b1;
                state_nxt = run ? ST_FETCH : ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Purpose: self-checking bench for instruction_sequencer with a microstep-queue reference model.
// Latency: checks every cycle on the falling edge.
// Backpressure: n/a (bench).
module tb_instruction_sequencer;

    localparam int N = 4;
    localparam int W = 9;

    // Microstep kinds of the reference model: each instruction expands into a
    // list of cycles; an empty list means the sequencer is idle.
    localparam int K_FETCH = 1;
    localparam int K_EXEC  = 2;  // single-cycle execute of mv/mvi/jmp/jnz/nop
    localparam int K_ALOAD = 3;  // add/sub operand A
    localparam int K_GLOAD = 4;  // add/sub ALU op
    localparam int K_WB    = 5;  // add/sub write-back

    typedef struct packed {
        logic       pce;
        logic       sload;
        logic [3:0] pdata;
        logic [7:0] rw;
        logic [3:0] sel;
        logic       al;
        logic       gl;
        logic       sub;
        logic       dn;
    } outs_t;

    logic         clock = 1'b0;
    logic         sreset;
    logic         run;
    logic [W-1:0] instr;
    logic [W-1:0] bus_value;
    logic         g_zero;
    logic         pc_count_enable;
    logic         pc_sload;
    logic [N-1:0] pc_data;
    logic [7:0]   reg_write;
    logic [3:0]   bus_sel;
    logic         a_load;
    logic         g_load;
    logic         alu_sub;
    logic         done;

    logic [W-1:0] rom [16];
    logic [N-1:0] pc;

    int checks   = 0;
    int failures = 0;

    int         mq[$];
    logic [8:0] m_ir = '0;

    instruction_sequencer #(.N(N), .W(W)) dut (
        .clock           (clock),
        .sreset          (sreset),
        .run             (run),
        .instr           (instr),
        .bus_value       (bus_value),
        .g_zero          (g_zero),
        .pc_count_enable (pc_count_enable),
        .pc_sload        (pc_sload),
        .pc_data         (pc_data),
        .reg_write       (reg_write),
        .bus_sel         (bus_sel),
        .a_load          (a_load),
        .g_load          (g_load),
        .alu_sub         (alu_sub),
        .done            (done)
    );

    always #5 clock = ~clock;

    // Program counter environment: combinational ROM read at the current PC.
    always @(posedge clock) begin
        if (sreset)               pc <= '0;
        else if (pc_sload)        pc <= pc_data;
        else if (pc_count_enable) pc <= pc + 1'b1;
    end
    assign instr = rom[pc];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic outs_t model_outs(input int kind, input logic [8:0] w,
                                         input logic gz, input logic [8:0] bv);
        outs_t      o;
        logic [2:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
        o  = '0;
        op = w[8:6];
        rx = w[5:3];
        ry = w[2:0];
        case (kind)
            K_FETCH: o.pce = 1'b1;
            K_EXEC: begin
                o.dn = 1'b1;
                if (op == 3'd0) begin
                    o.sel = {1'b0, ry};
                    o.rw  = 8'd1 << rx;
                end else if (op == 3'd1) begin
                    o.sel = 4'd9;
                    o.rw  = 8'd1 << rx;
                    o.pce = 1'b1;
                end else if (op == 3'd4 || (op == 3'd5 && !gz)) begin
                    o.sel   = {1'b0, ry};
                    o.sload = 1'b1;
                    o.pdata = bv[3:0];
                end else if (op == 3'd5) begin
                    o.sel = {1'b0, ry};
                end
            end
            K_ALOAD: begin
                o.sel = {1'b0, rx};
                o.al  = 1'b1;
            end
            K_GLOAD: begin
                o.sel = {1'b0, ry};
                o.gl  = 1'b1;
                o.sub = (op == 3'd3);
            end
            K_WB: begin
                o.sel = 4'd8;
                o.rw  = 8'd1 << rx;
                o.dn  = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Compare process: check this cycle against the model, then advance the
    // model using the inputs that the next rising edge will sample.
    always @(negedge clock) begin
        outs_t e;
        int    k;
        e = model_outs(mq.size() > 0 ? mq[0] : 0, m_ir, g_zero, bus_value);
        chk("pc_count_enable", pc_count_enable, e.pce);
        chk("pc_sload", pc_sload, e.sload);
        chk("pc_data", pc_data, e.pdata);
        chk("reg_write", reg_write, e.rw);
        chk("bus_sel", bus_sel, e.sel);
        chk("a_load", a_load, e.al);
        chk("g_load", g_load, e.gl);
        chk("alu_sub", alu_sub, e.sub);
        chk("done", done, e.dn);
        chk("inv_pc_exclusive", int'(pc_count_enable & pc_sload), 0);
        chk("inv_reg_write_onehot", int'($countones(reg_write) <= 1), 1);
        chk("inv_pc_data_zero", int'(!pc_sload && pc_data != '0), 0);

        if (sreset) begin
            mq.delete();
        end else if (mq.size() == 0) begin
            if (run) mq.push_back(K_FETCH);
        end else begin
            k = mq.pop_front();
            if (k == K_FETCH) begin
                m_ir = instr[8:0];
                if (m_ir[8:6] == 3'd2 || m_ir[8:6] == 3'd3) begin
                    mq.push_back(K_ALOAD);
                    mq.push_back(K_GLOAD);
                    mq.push_back(K_WB);
                end else begin
                    mq.push_back(K_EXEC);
                end
            end else if ((k == K_EXEC || k == K_WB) && run) begin
                mq.push_back(K_FETCH);
            end
        end
    end

    task automatic nxt;
        @(posedge clock);
        #1;
    endtask

    task automatic smp;
        @(negedge clock);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_ctl"}, {pc_count_enable, pc_sload, a_load, g_load, alu_sub, done}, 0);
        chk({name, "_rw"}, reg_write, 0);
        chk({name, "_sel"}, bus_sel, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[0]  = 9'b001_011_000;  // mvi r3
        rom[1]  = 9'h005;          // immediate
        rom[2]  = 9'b000_010_011;  // mv r2, r3
        rom[3]  = 9'b011_001_010;  // sub r1, r2
        rom[4]  = 9'b101_000_100;  // jnz via r4 (taken)
        rom[12] = 9'b101_000_100;  // jnz via r4 (not taken)
        rom[13] = 9'b010_001_010;  // add r1, r2
        sreset    = 1'b1;
        run       = 1'b1;
        g_zero    = 1'b0;
        bus_value = '0;

        // Reset held with run=1.
        smp; chk_idle("rst0");
        nxt; smp; chk_idle("rst1");
        nxt; sreset = 1'b0;
        smp; chk_idle("rst_last");
        nxt; smp;                                  // C1 FETCH
        chk("c1_fetch_pce", pc_count_enable, 1);
        nxt; smp;                                  // C2 mvi
        chk("mvi_sel", bus_sel, 9);
        chk("mvi_rw", reg_write, 8'h08);
        chk("mvi_pce", pc_count_enable, 1);
        chk("mvi_done", done, 1);
        nxt; smp;                                  // C3 FETCH
        nxt; smp;                                  // C4 mv
        chk("mv_sel", bus_sel, 3);
        chk("mv_rw", reg_write, 8'h04);
        nxt; smp;                                  // C5 FETCH sub
        chk("pc_after_mvi_mv", pc, 3);
        nxt; smp;                                  // C6 sub T1
        chk("sub_t1", {bus_sel, a_load, done}, {4'd1, 1'b1, 1'b0});
        nxt; smp;                                  // C7 sub T2
        chk("sub_t2", {bus_sel, g_load, alu_sub}, {4'd2, 1'b1, 1'b1});
        nxt; smp;                                  // C8 sub T3
        chk("sub_t3", {bus_sel, reg_write, done}, {4'd8, 8'h02, 1'b1});
        nxt; g_zero = 1'b0; bus_value = 9'h00C;    // C9 FETCH jnz
        smp;
        nxt; smp;                                  // C10 jnz taken
        chk("jnz_taken", {pc_sload, pc_data, pc_count_enable, done}, {1'b1, 4'hC, 1'b0, 1'b1});
        nxt; g_zero = 1'b1;                        // C11 FETCH at 0xC
        smp;
        chk("jnz_target_pc", pc, 12);
        nxt; smp;                                  // C12 jnz not taken
        chk("jnz_not_taken", {pc_sload, pc_data, done}, {1'b0, 4'h0, 1'b1});
        nxt; smp;                                  // C13 FETCH add
        nxt; smp;                                  // C14 add T1
        nxt; sreset = 1'b1;                        // C15 add T2, reset asserted
        smp;
        chk("add_t2_rw", reg_write, 0);
        nxt; sreset = 1'b0; run = 1'b0; rom[0] = 9'b010_001_010;
        smp; chk_idle("rst_mid_add");              // C16
        nxt; run = 1'b1;
        smp; chk_idle("idle_run0");                // C17
        nxt; smp;                                  // C18 FETCH
        chk("refetch_pce", pc_count_enable, 1);
        nxt; run = 1'b0;                           // C19 add T1
        smp;
        nxt; smp;                                  // C20 T2
        nxt; smp;                                  // C21 T3
        chk("run_drop_done", {done, reg_write}, {1'b1, 8'h02});
        for (int i = 0; i < 3; i++) begin
            nxt; smp; chk_idle("run_drop_idle");
        end

        // Randomized operation against the model.
        for (int c = 0; c < 3000; c++) begin
            nxt;
            run       = ($urandom_range(0, 9) != 0);
            sreset    = ($urandom_range(0, 49) == 0);
            g_zero    = 1'($urandom_range(0, 1));
            bus_value = W'($urandom);
            if ($urandom_range(0, 19) == 0) rom[$urandom_range(0, 15)] = W'($urandom);
        end
        smp;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
